attr_port_sequencer: RTL and testbench

Round-robin sequencer that shares one three-input/six-output port device (inputs `a`, `b`, `f`; outputs `c`, `d`, `e`, `g`, `h`, `i`) among `NREQ` requesters. The block grants one requester at a time and drives that requester's input triple onto the device. It holds the inputs for `SETTLE` cycles, then samples the six outputs and returns them with the requester's index. It sits in `top` between the request sources and the single shared device instance.

---
 rtl/attr_port_sequencer.sv | 138 +++++++++++++
 tb/tb_attr_port_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/attr_port_sequencer.sv
// Round-robin sequencer sharing one 3-in/6-out port device among NREQ
// requesters: drive a triple, settle, sample, answer with the requester id.
module attr_port_sequencer #(
  parameter int NREQ = 4,
  parameter int SETTLE = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              dut_a,
  output logic              dut_b,
  output logic              dut_f,
  input  logic [5:0]        dut_out,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [5:0]        rsp_data,
  output logic              busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  if (SETTLE < 1) begin : g_bad_settle
    $error("attr_port_sequencer: SETTLE must be >= 1");
  end
  if (NREQ < 1) begin : g_bad_nreq
    $error("attr_port_sequencer: NREQ must be >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    drv_q, drv_d;
  logic          rv_q, rv_d;
  logic [IW-1:0] id_q, id_d;
  logic [5:0]    dat_q, dat_d;

  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt;
  logic [2:0]    trip;

  // First valid requester at or above the pointer, wrapping mod NREQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    trip = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == sel) trip = req_data[3*k +: 3];
    end
    nxt = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && found && !rst) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    rv_d    = rv_q;
    id_d    = id_q;
    dat_d   = dat_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (found) begin
          drv_d   = trip;
          id_d    = sel;
          cnt_d   = CW'(SETTLE - 1);
          ptr_d   = nxt;
          state_d = S_DRIVE;
        end
      end
      state_q == S_DRIVE: begin
        if (cnt_q == '0) begin
          dat_d   = dut_out;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        rv_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      rv_q    <= 1'b0;
      id_q    <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      rv_q    <= rv_d;
      id_q    <= id_d;
      dat_q   <= dat_d;
    end
  end

  assign dut_a     = drv_q[2];
  assign dut_b     = drv_q[1];
  assign dut_f     = drv_q[0];
  assign rsp_valid = rv_q;
  assign rsp_id    = id_q;
  assign rsp_data  = dat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_attr_port_sequencer.sv
// Scoreboard bench for attr_port_sequencer: SETTLE=2 and SETTLE=1 copies
// share stimulus; a negedge monitor checks grants and responses.
module tb_attr_port_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_data = '0;

  logic [3:0] rdy2, rdy1;
  logic       a2, b2, f2, a1, b1, f1;
  logic [5:0] o2, o1;
  logic       rv2, rv1;
  logic [1:0] id2, id1;
  logic [5:0] rd2, rd1;
  logic       bz2, bz1;

  assign o2 = {a2, b2, f2, ~a2, ~b2, ~f2};
  assign o1 = {a1, b1, f1, ~a1, ~b1, ~f1};

  attr_port_sequencer #(.NREQ(4), .SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy2), .dut_a(a2), .dut_b(b2), .dut_f(f2), .dut_out(o2),
    .rsp_valid(rv2), .rsp_id(id2), .rsp_data(rd2), .busy(bz2)
  );

  attr_port_sequencer #(.NREQ(4), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .dut_a(a1), .dut_b(b1), .dut_f(f1), .dut_out(o1),
    .rsp_valid(rv1), .rsp_id(id1), .rsp_data(rd1), .busy(bz1)
  );

  int sel_dut = 0;
  logic [3:0] m_ready;
  logic [2:0] m_abf;
  logic       m_rv;
  logic [1:0] m_id;
  logic [5:0] m_rd;
  logic       m_busy;

  always_comb begin
    if (sel_dut == 1) begin
      m_ready = rdy1; m_abf = {a1, b1, f1}; m_rv = rv1;
      m_id = id1; m_rd = rd1; m_busy = bz1;
    end else begin
      m_ready = rdy2; m_abf = {a2, b2, f2}; m_rv = rv2;
      m_id = id2; m_rd = rd2; m_busy = bz2;
    end
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [5:0] data;
    int         lat;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  int   exp_gap[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_gnt(input int id, input int gap);
    exp_gnt.push_back(id);
    exp_gap.push_back(gap);
  endtask

  task automatic push_rsp(input int id, input logic [5:0] d, input int lat);
    rsp_t r;
    r.id = id; r.data = d; r.lat = lat;
    exp_rsp.push_back(r);
  endtask

  int   g_mon, e_mon, gp_mon, ac_mon;
  rsp_t r_mon;

  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
    end else begin
      if ((m_ready & req_valid) != 4'b0) begin
        g_mon = 0;
        for (int k = 0; k < 4; k++) if (m_ready[k]) g_mon = k;
        n_acc++;
        if (exp_gnt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_unexpected: got req_ready %b expected none",
                   m_ready);
        end else begin
          e_mon  = exp_gnt.pop_front();
          gp_mon = exp_gap.pop_front();
          chk("grant_vec", 32'(m_ready), 32'(1 << e_mon));
          if (gp_mon >= 0) chk("accept_gap", cyc - last_acc, gp_mon);
        end
        last_acc = cyc;
        acc_q.push_back(cyc);
      end
      if (m_rv) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got id %0d data %b expected none",
                   m_id, m_rd);
        end else begin
          r_mon = exp_rsp.pop_front();
          chk("rsp_id", 32'(m_id), r_mon.id);
          chk("rsp_data", 32'(m_rd), 32'(r_mon.data));
          ac_mon = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          chk("rsp_latency", cyc - ac_mon - 1, r_mon.lat);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 60; i++) begin
      if (n_acc >= target) break;
      tick();
    end
    chk("accept_reached", n_acc, target);
  endtask

  task automatic wait_idle(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!m_busy) break;
      nb++;
      tick();
    end
    chk("idle_reached", 32'(m_busy), 0);
  endtask

  int nb;
  int n0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every requester asking
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 12'hfff;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(m_ready), 0);
      chk("rst_busy", 32'(m_busy), 0);
      chk("rst_rsp_valid", 32'(m_rv), 0);
      chk("rst_abf", 32'(m_abf), 0);
      chk("rst_rsp_data", 32'(m_rd), 0);
      chk("rst_rsp_id", 32'(m_id), 0);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request from requester 2
    req_data = 12'b000_101_000_000;
    push_gnt(2, -1);
    push_rsp(2, 6'b101010, 2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("abf_after_accept", 32'(m_abf), 32'(3'b101));
    wait_idle(nb);
    chk("busy_cycles", nb, 3);

    // Fresh pointer, then fair rotation across all four
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = 12'b110_011_100_001;
    push_gnt(0, -1); push_rsp(0, 6'b001110, 2);
    push_gnt(1, 4);  push_rsp(1, 6'b100011, 2);
    push_gnt(2, 4);  push_rsp(2, 6'b011100, 2);
    push_gnt(3, 4);  push_rsp(3, 6'b110001, 2);
    push_gnt(0, 4);  push_rsp(0, 6'b001110, 2);
    n0 = n_acc;
    req_valid = 4'b1111;
    wait_acc(n0 + 5);
    req_valid = '0;
    wait_idle(nb);

    // Serve 3 so the pointer wraps, then only 1 and 2 ask
    push_gnt(3, -1); push_rsp(3, 6'b110001, 2);
    n0 = n_acc;
    req_valid = 4'b1000;
    wait_acc(n0 + 1);
    req_valid = '0;
    wait_idle(nb);
    push_gnt(1, -1); push_rsp(1, 6'b100011, 2);
    push_gnt(2, 4);  push_rsp(2, 6'b011100, 2);
    n0 = n_acc;
    req_valid = 4'b0110;
    wait_acc(n0 + 2);
    req_valid = '0;
    wait_idle(nb);

    // Abort during DRIVE; next grant restarts from pointer 0
    push_gnt(1, -1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_busy", 32'(m_busy), 0);
    push_gnt(0, -1); push_rsp(0, 6'b001110, 2);
    n0 = n_acc;
    req_valid = 4'b1111;
    wait_acc(n0 + 1);
    req_valid = '0;
    wait_idle(nb);

    // SETTLE=1 copy: short latency, 3-cycle spacing, dropped requester
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sel_dut = 1;
    push_gnt(0, -1); push_rsp(0, 6'b001110, 1);
    push_gnt(1, 3);  push_rsp(1, 6'b100011, 1);
    n0 = n_acc;
    req_valid = 4'b0011;
    wait_acc(n0 + 1);
    req_valid = 4'b0111;
    tick();
    req_valid = 4'b0011;
    wait_acc(n0 + 2);
    req_valid = '0;
    wait_idle(nb);
    chk("s1_busy_cycles", nb, 2);
    for (int i = 0; i < 3; i++) tick();

    chk("leftover_grants", exp_gnt.size(), 0);
    chk("leftover_rsps", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
